util_fft_ctrl: RTL and testbench

Multi-channel, runtime-configurable framing and handshake controller for an AXI4-Stream FFT/IFFT core. It sits between the per-antenna sample streams and the FFT core ports. Per frame it latches size and direction, issues the core config word, and generates input `tlast` from a sample counter. On the output side it carries the channel tag across the core, regenerates `sop`/`eop`/index and flags framing errors. The core itself is instantiated outside this block; only its AXIS ports connect here.

---
 rtl/util_fft_pkg.sv | 37 +++
 rtl/util_fft_tag_fifo.sv | 50 +++++
 rtl/util_fft_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_util_fft_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/util_fft_pkg.sv
// Shared types and helpers for the FFT framing controller: config word layout,
// size clamp, input FSM states and the per-frame tag carried across the core.
package util_fft_pkg;

    localparam int CFG_W        = 16;
    localparam int CFG_INV_BIT  = 8;
    localparam int CFG_NFFT_LSB = 0;
    localparam int NFFT_W       = 5;
    localparam int TAG_CHAN_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CFG  = 2'd1,
        ST_DATA = 2'd2
    } in_state_t;

    typedef struct packed {
        logic [TAG_CHAN_W-1:0] chan;
        logic [NFFT_W-1:0]     nfft;
    } tag_t;

    function automatic logic [NFFT_W-1:0] clamp_nfft(input logic [NFFT_W-1:0] n,
                                                     input int lo, input int hi);
        if (int'(n) < lo) return NFFT_W'(lo);
        if (int'(n) > hi) return NFFT_W'(hi);
        return n;
    endfunction

    function automatic logic [CFG_W-1:0] cfg_word(input logic [NFFT_W-1:0] n, input logic inv);
        logic [CFG_W-1:0] w;
        w = '0;
        w[CFG_INV_BIT] = inv;
        w[CFG_NFFT_LSB +: NFFT_W] = n;
        return w;
    endfunction

endpackage

// File: rtl/util_fft_tag_fifo.sv
// Small synchronous FIFO holding one {chan, nfft} tag per frame in flight
// through the FFT core. DEPTH must be a power of two.
module util_fft_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/util_fft_ctrl.sv
// Framing/handshake controller in front of and behind an AXIS FFT core: per-frame
// config issue and input tlast generation, output tag/index regeneration.
module util_fft_ctrl
    import util_fft_pkg::*;
#(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 16,
    parameter int NUM_CH    = 4,
    parameter int MIN_LOG2  = 7,
    parameter int MAX_LOG2  = 12,
    parameter int TAG_DEPTH = 4,
    parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4:0]            cfg_nfft,
    input  logic                  cfg_inverse,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [CH_W-1:0]       s_chan,
    input  logic [IN_W-1:0]       s_real,
    input  logic [IN_W-1:0]       s_imag,
    output logic [15:0]           core_cfg_tdata,
    output logic                  core_cfg_tvalid,
    input  logic                  core_cfg_tready,
    output logic [2*IN_W-1:0]     core_din_tdata,
    output logic                  core_din_tvalid,
    output logic                  core_din_tlast,
    input  logic                  core_din_tready,
    input  logic [2*OUT_W-1:0]    core_dout_tdata,
    input  logic [7:0]            core_dout_tuser,
    input  logic                  core_dout_tvalid,
    input  logic                  core_dout_tlast,
    output logic                  core_dout_tready,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_sop,
    output logic                  m_eop,
    output logic [OUT_W-1:0]      m_real,
    output logic [OUT_W-1:0]      m_imag,
    output logic [5:0]            m_exp,
    output logic [CH_W-1:0]       m_chan,
    output logic [MAX_LOG2-1:0]   m_index,
    output logic                  m_err
);

    localparam int BEAT_W = 1 + 6 + 2*OUT_W;

    function automatic logic [MAX_LOG2-1:0] last_idx(input logic [NFFT_W-1:0] n);
        return MAX_LOG2'((32'd1 << n) - 32'd1);
    endfunction

    in_state_t             state, state_n;
    logic [NFFT_W-1:0]     nfft_q, nfft_clamped;
    logic                  inv_q;
    logic [MAX_LOG2-1:0]   in_cnt;
    logic                  in_fire;
    tag_t                  tag_in, tag_head;
    logic                  tag_push, tag_pop, tag_full, tag_empty;

    assign nfft_clamped   = clamp_nfft(cfg_nfft, MIN_LOG2, MAX_LOG2);
    assign tag_in         = {TAG_CHAN_W'(s_chan), nfft_clamped};
    assign core_cfg_tdata = cfg_word(nfft_q, inv_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    // The first beat is held at the source until DATA; only its sideband is sampled in IDLE.
    always_comb begin
        state_n         = state;
        s_ready         = 1'b0;
        core_cfg_tvalid = 1'b0;
        core_din_tvalid = 1'b0;
        core_din_tlast  = 1'b0;
        core_din_tdata  = '0;
        tag_push        = 1'b0;
        in_fire         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s_valid && !tag_full) begin
                    tag_push = 1'b1;
                    state_n  = ST_CFG;
                end
            end
            ST_CFG: begin
                core_cfg_tvalid = 1'b1;
                if (core_cfg_tready) state_n = ST_DATA;
            end
            ST_DATA: begin
                s_ready         = core_din_tready;
                core_din_tvalid = s_valid;
                core_din_tdata  = {s_real, s_imag};
                core_din_tlast  = (in_cnt == last_idx(nfft_q));
                in_fire         = s_valid & core_din_tready;
                if (in_fire && core_din_tlast) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nfft_q <= '0;
            inv_q  <= 1'b0;
            in_cnt <= '0;
        end else begin
            if (tag_push) begin
                nfft_q <= nfft_clamped;
                inv_q  <= cfg_inverse;
            end
            if (in_fire) in_cnt <= core_din_tlast ? '0 : in_cnt + MAX_LOG2'(1);
        end
    end

    util_fft_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     ($bits(tag_t))
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tag_push),
        .din   (tag_in),
        .pop   (tag_pop),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty)
    );

    logic [BEAT_W-1:0]   sbuf [2];
    logic                wr_sel, rd_sel, rdy_en, orphan_err;
    logic [1:0]          buf_cnt;
    logic [MAX_LOG2-1:0] out_idx;
    logic                buf_pop, dout_fire, m_fire, at_last, head_last;
    logic [5:0]          head_exp;
    logic [2*OUT_W-1:0]  head_data;

    assign {head_last, head_exp, head_data} = sbuf[rd_sel];

    // rdy_en keeps tready low while in reset and raises it on the first clock after.
    assign core_dout_tready = rdy_en & (buf_cnt != 2'd2);
    assign dout_fire        = core_dout_tvalid & core_dout_tready;
    assign m_valid          = (buf_cnt != 2'd0) & ~tag_empty;
    assign m_fire           = m_valid & m_ready;
    // Beats with no frame tag to attribute them to are discarded here.
    assign buf_pop          = (buf_cnt != 2'd0) & (tag_empty | m_ready);
    assign at_last          = (out_idx == last_idx(tag_head.nfft));
    assign tag_pop          = m_fire & at_last;

    assign m_real  = head_data[2*OUT_W-1:OUT_W];
    assign m_imag  = head_data[OUT_W-1:0];
    assign m_exp   = head_exp;
    assign m_index = out_idx;
    assign m_sop   = m_valid & (out_idx == '0);
    assign m_eop   = m_valid & at_last;
    assign m_err   = m_valid & (head_last ^ at_last);
    assign m_chan  = m_valid ? tag_head.chan[CH_W-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbuf[0]    <= '0;
            sbuf[1]    <= '0;
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b0;
            buf_cnt    <= '0;
            rdy_en     <= 1'b0;
            out_idx    <= '0;
            orphan_err <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (dout_fire) begin
                sbuf[wr_sel] <= {core_dout_tlast, core_dout_tuser[5:0], core_dout_tdata};
                wr_sel       <= ~wr_sel;
            end
            if (buf_pop) rd_sel <= ~rd_sel;
            buf_cnt <= buf_cnt + 2'(dout_fire) - 2'(buf_pop);
            if (buf_pop && tag_empty) orphan_err <= 1'b1;
            if (m_fire) out_idx <= at_last ? '0 : out_idx + MAX_LOG2'(1);
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, core_dout_tuser[7:6], orphan_err, tag_head.chan};

endmodule

// File: tb/tb_util_fft_ctrl.sv
// Directed phases with random sample data against a frame-level reference model
// and a fixed-latency loopback model of the FFT core.
module tb_util_fft_ctrl;

    localparam int LAT  = 10;
    localparam int MAXL = 12;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [4:0]  cfg_nfft;
    logic        cfg_inverse, s_valid, s_ready;
    logic [1:0]  s_chan;
    logic [15:0] s_real, s_imag;
    logic [15:0] core_cfg_tdata;
    logic        core_cfg_tvalid, core_cfg_tready;
    logic [31:0] core_din_tdata;
    logic        core_din_tvalid, core_din_tlast, core_din_tready;
    logic [31:0] core_dout_tdata;
    logic [7:0]  core_dout_tuser;
    logic        core_dout_tvalid, core_dout_tlast, core_dout_tready;
    logic        m_valid, m_ready, m_sop, m_eop, m_err;
    logic [15:0] m_real, m_imag;
    logic [5:0]  m_exp;
    logic [1:0]  m_chan;
    logic [MAXL-1:0] m_index;

    always #5 clk = ~clk;

    util_fft_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cfg_nfft(cfg_nfft), .cfg_inverse(cfg_inverse),
        .s_valid(s_valid), .s_ready(s_ready), .s_chan(s_chan), .s_real(s_real), .s_imag(s_imag),
        .core_cfg_tdata(core_cfg_tdata), .core_cfg_tvalid(core_cfg_tvalid),
        .core_cfg_tready(core_cfg_tready), .core_din_tdata(core_din_tdata),
        .core_din_tvalid(core_din_tvalid), .core_din_tlast(core_din_tlast),
        .core_din_tready(core_din_tready), .core_dout_tdata(core_dout_tdata),
        .core_dout_tuser(core_dout_tuser), .core_dout_tvalid(core_dout_tvalid),
        .core_dout_tlast(core_dout_tlast), .core_dout_tready(core_dout_tready),
        .m_valid(m_valid), .m_ready(m_ready), .m_sop(m_sop), .m_eop(m_eop),
        .m_real(m_real), .m_imag(m_imag), .m_exp(m_exp), .m_chan(m_chan),
        .m_index(m_index), .m_err(m_err)
    );

    typedef struct {
        logic [31:0] data; logic [4:0] nraw; logic inv; logic [1:0] chan;
        logic first; logic last; logic core_last; logic [7:0] tuser;
    } src_t;
    typedef struct { logic [31:0] data; logic last; logic [7:0] tuser; int rel; } pipe_t;
    typedef struct {
        logic [31:0] data; logic [1:0] chan; int idx; logic sop, eop, err; logic [5:0] ex;
    } exp_t;

    src_t        src_q[$];
    pipe_t       pipe_q[$];
    exp_t        exp_q[$];
    logic [15:0] exp_cfg[$];

    int   vectors = 0, miscompares = 0;
    int   cyc = 0, cfg_cnt = 0, eop_cnt = 0, occ = 0, last_tlast_cyc = -1, frame_seq = 0;
    int   mready_mode = 0;
    bit   check_gap = 0, core_stall = 0, rand_hs = 0, hold_vld = 0;
    logic [63:0] hold_val;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Frame-level reference: clamp, config word, and every expected output beat.
    task automatic add_frame(input logic [4:0] nraw, input logic inv, input logic [1:0] chan,
                             input int inj);
        int nf, n;
        logic [7:0] tu;
        src_t s;
        exp_t e;
        nf = int'(nraw);
        if (nf < 7)  nf = 7;
        if (nf > 12) nf = 12;
        n = 1 << nf;
        exp_cfg.push_back((16'(inv) << 8) | 16'(nf));
        tu = {2'($urandom), 6'(frame_seq)};
        frame_seq++;
        for (int i = 0; i < n; i++) begin
            s.data = $urandom; s.nraw = nraw; s.inv = inv; s.chan = chan;
            s.first = (i == 0); s.last = (i == n-1);
            s.core_last = (inj >= 0) ? (i == inj) : s.last;
            s.tuser = tu;
            src_q.push_back(s);
            e.data = s.data; e.chan = chan; e.idx = i; e.sop = (i == 0); e.eop = s.last;
            e.err = s.core_last ^ s.last; e.ex = tu[5:0];
            exp_q.push_back(e);
        end
    endtask

    // One clock: drive at negedge, sample 1 ns later, account for the transfers of the next posedge.
    task automatic step();
        int   din_acc, m_acc;
        exp_t e;
        pipe_t p;
        @(negedge clk);
        if (src_q.size() > 0) begin
            s_valid = 1'b1;
            {s_real, s_imag} = src_q[0].data;
            cfg_nfft = src_q[0].nraw; cfg_inverse = src_q[0].inv; s_chan = src_q[0].chan;
        end else s_valid = 1'b0;
        core_cfg_tready = rand_hs ? 1'($urandom_range(0, 1)) : 1'b1;
        core_din_tready = rand_hs ? 1'($urandom_range(0, 1)) : 1'b1;
        case (mready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
        if (!core_stall && pipe_q.size() > 0 && pipe_q[0].rel <= cyc) begin
            core_dout_tvalid = 1'b1; core_dout_tdata = pipe_q[0].data;
            core_dout_tlast = pipe_q[0].last; core_dout_tuser = pipe_q[0].tuser;
        end else begin
            core_dout_tvalid = 1'b0; core_dout_tlast = 1'b0;
        end
        #1;
        chk("dout_tready", 64'(core_dout_tready), 64'(occ < 2));
        chk("m_valid", 64'(m_valid), 64'(occ > 0));
        if (hold_vld)
            chk("m_hold", {m_valid, m_sop, m_eop, m_err, m_chan, m_exp, m_index, m_real, m_imag}, hold_val);
        if (core_cfg_tvalid && core_cfg_tready) begin
            if (exp_cfg.size() == 0) chk("cfg_unexpected", 64'(core_cfg_tvalid), 64'd0);
            else begin
                chk("cfg_word", 64'(core_cfg_tdata), 64'(exp_cfg.pop_front()));
                cfg_cnt++;
                chk("tag_limit", 64'(cfg_cnt - eop_cnt <= 4), 64'd1);
            end
        end
        if (core_din_tvalid && core_din_tready) chk("din_src", 64'(s_valid & s_ready), 64'd1);
        din_acc = 0;
        if (s_valid && s_ready) begin
            chk("din_hs", 64'({core_din_tvalid, core_din_tready}), 64'd3);
            chk("din_data", 64'(core_din_tdata), 64'(src_q[0].data));
            chk("din_tlast", 64'(core_din_tlast), 64'(src_q[0].last));
            if (check_gap && src_q[0].first && last_tlast_cyc >= 0)
                chk("frame_gap", 64'(cyc - last_tlast_cyc), 64'd3);
            if (src_q[0].last) last_tlast_cyc = cyc;
            p.data = src_q[0].data; p.last = src_q[0].core_last;
            p.tuser = src_q[0].tuser; p.rel = cyc + LAT;
            pipe_q.push_back(p);
            void'(src_q.pop_front());
            din_acc = 1;
        end
        if (din_acc == 0 && core_din_tvalid && core_din_tready) din_acc = 0;
        if (core_dout_tvalid && core_dout_tready) begin
            void'(pipe_q.pop_front());
            occ++;
        end
        m_acc = 0;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("m_unexpected", 64'(m_valid), 64'd0);
            else begin
                e = exp_q.pop_front();
                chk("m_data", 64'({m_real, m_imag}), 64'(e.data));
                chk("m_index", 64'(m_index), 64'(e.idx));
                chk("m_chan", 64'(m_chan), 64'(e.chan));
                chk("m_sop_eop_err", 64'({m_sop, m_eop, m_err}), 64'({e.sop, e.eop, e.err}));
                chk("m_exp", 64'(m_exp), 64'(e.ex));
                if (e.eop) eop_cnt++;
            end
            m_acc = 1;
        end
        occ -= m_acc;
        hold_vld = m_valid && !m_ready;
        hold_val = {m_valid, m_sop, m_eop, m_err, m_chan, m_exp, m_index, m_real, m_imag};
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_done", 64'(src_q.size() + exp_q.size()), 64'd0);
    endtask

    initial begin
        int n, base;
        s_valid = 0; s_chan = 0; s_real = 0; s_imag = 0; cfg_nfft = 0; cfg_inverse = 0;
        core_cfg_tready = 1; core_din_tready = 1; core_dout_tvalid = 0; core_dout_tlast = 0;
        core_dout_tdata = 0; core_dout_tuser = 0; m_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_cfg_tvalid", 64'(core_cfg_tvalid), 64'd0);
        chk("rst_din_tvalid", 64'({core_din_tvalid, core_din_tlast}), 64'd0);
        chk("rst_m_flags", 64'({m_valid, m_sop, m_eop, m_err}), 64'd0);
        chk("rst_dout_tready", 64'(core_dout_tready), 64'd0);
        chk("rst_m_index", 64'(m_index), 64'd0);
        rst_n = 1'b1;

        // 128-point FFT frame, with a short output stall to fill the skid buffer
        add_frame(5'd7, 1'b0, 2'd0, -1);
        repeat (60) step();
        mready_mode = 2;
        repeat (5) step();
        chk("skid_full_tready", 64'(core_dout_tready), 64'd0);
        mready_mode = 0;
        drain(2000);

        // back-to-back IFFT frames on all channels
        check_gap = 1; last_tlast_cyc = -1;
        for (int c = 0; c < 4; c++) add_frame(5'd8, 1'b1, 2'(c), -1);
        drain(3000);
        check_gap = 0;

        // size clamp at both ends
        add_frame(5'd3, 1'b0, 2'd1, -1);
        add_frame(5'd15, 1'b1, 2'd2, -1);
        drain(6000);

        // early core tlast at beat 100
        add_frame(5'd7, 1'b0, 2'd3, 100);
        drain(2000);

        // random handshakes on every port
        rand_hs = 1; mready_mode = 1;
        for (int k = 0; k < 3; k++)
            add_frame(5'($urandom_range(7, 9)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), -1);
        drain(8000);
        rand_hs = 0; mready_mode = 0;

        // tag FIFO full: fifth frame must wait for the first output eop
        core_stall = 1; base = cfg_cnt;
        for (int k = 0; k < 5; k++) add_frame(5'd7, 1'b0, 2'(k % 4), -1);
        repeat (4*131 + 40) step();
        chk("fifo_full_s_ready", 64'(s_ready), 64'd0);
        chk("fifo_full_cfg_tvalid", 64'(core_cfg_tvalid), 64'd0);
        chk("fifo_full_cfgs", 64'(cfg_cnt - base), 64'd4);
        chk("fifo_full_held", 64'(src_q.size()), 64'd128);
        core_stall = 0;
        drain(3000);

        // asynchronous reset in the middle of DATA
        add_frame(5'd7, 1'b0, 2'd1, -1);
        n = 0;
        step();
        while (!s_ready && n < 20) begin
            step();
            n++;
        end
        chk("pre_reset_in_data", 64'(s_ready), 64'd1);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
        chk("mid_rst_cfg_din", 64'({core_cfg_tvalid, core_din_tvalid, core_din_tlast}), 64'd0);
        chk("mid_rst_din_data", 64'(core_din_tdata), 64'd0);
        chk("mid_rst_m_flags", 64'({m_valid, m_sop, m_eop, m_err}), 64'd0);
        chk("mid_rst_dout_tready", 64'(core_dout_tready), 64'd0);
        chk("mid_rst_m_index", 64'(m_index), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
